// File: rtl/seg7_scan_ctrl.sv
// Eight-digit multiplexed 7-seg driver; loads are staged and committed only at frame end.
// Outputs registered (1 cycle); optional leading-zero blanking via SEG7_LZ_BLANK_EN.
module seg7_scan_ctrl #(
   parameter int unsigned DIV_W = 17
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [31:0] data_i,
   input  logic        load_i,
   input  logic        en_i,
   output logic [7:0]  disp_seg_o,
   output logic [7:0]  disp_an_o,
   output logic        frame_o
);

   logic [DIV_W-1:0] presc_q, presc_d;
   logic [2:0]       idx_q, idx_d;
   logic [31:0]      shadow_q, shadow_d;
   logic [31:0]      disp_q, disp_d;
   logic             pending_q, pending_d;
   logic [7:0]       an_q, an_d;
   logic [7:0]       seg_q, seg_d;
   logic             frame_q;
   logic             tick;
   logic             frame_end;
   logic [4:0]       nib_sh;
   logic [3:0]       nib;
`ifdef SEG7_LZ_BLANK_EN
   logic             lz_blank;
`endif

   function automatic logic [7:0] hex7(input logic [3:0] v);
      logic [7:0] s;
      case (v)
         4'h0: s = 8'hC0;
         4'h1: s = 8'hF9;
         4'h2: s = 8'hA4;
         4'h3: s = 8'hB0;
         4'h4: s = 8'h99;
         4'h5: s = 8'h92;
         4'h6: s = 8'h82;
         4'h7: s = 8'hF8;
         4'h8: s = 8'h80;
         4'h9: s = 8'h90;
         4'hA: s = 8'h88;
         4'hB: s = 8'h83;
         4'hC: s = 8'hC6;
         4'hD: s = 8'hA1;
         4'hE: s = 8'h86;
         default: s = 8'h8E;
      endcase
      return s;
   endfunction

   assign tick      = &presc_q;
   assign frame_end = tick && (idx_q == 3'd7);

   always_comb begin
      presc_d   = presc_q + {{(DIV_W-1){1'b0}}, 1'b1};
      idx_d     = tick ? idx_q + 3'd1 : idx_q;
      shadow_d  = load_i ? data_i : shadow_q;
      disp_d    = disp_q;
      pending_d = pending_q;
      if (frame_end) begin
         // A load landing on the commit edge wins over the older staged value.
         if (load_i)
            disp_d = data_i;
         else if (pending_q)
            disp_d = shadow_q;
         pending_d = 1'b0;
      end else if (load_i) begin
         pending_d = 1'b1;
      end
   end

   assign nib_sh = {idx_d, 2'b00};
   assign nib    = disp_d[nib_sh +: 4];
`ifdef SEG7_LZ_BLANK_EN
   assign lz_blank = (idx_d != 3'd0) && ((disp_d >> nib_sh) == 32'd0);
`endif

   always_comb begin
      an_d  = 8'hFF;
      seg_d = 8'hFF;
      if (en_i) begin
         an_d  = ~(8'b1 << idx_d);
         seg_d = hex7(nib);
`ifdef SEG7_LZ_BLANK_EN
         if (lz_blank) begin
            an_d  = 8'hFF;
            seg_d = 8'hFF;
         end
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         presc_q   <= '0;
         idx_q     <= 3'd0;
         shadow_q  <= 32'd0;
         disp_q    <= 32'd0;
         pending_q <= 1'b0;
         an_q      <= 8'hFF;
         seg_q     <= 8'hFF;
         frame_q   <= 1'b0;
      end else begin
         presc_q   <= presc_d;
         idx_q     <= idx_d;
         shadow_q  <= shadow_d;
         disp_q    <= disp_d;
         pending_q <= pending_d;
         an_q      <= an_d;
         seg_q     <= seg_d;
         frame_q   <= frame_end;
      end
   end

   assign disp_an_o  = an_q;
   assign disp_seg_o = seg_q;
   assign frame_o    = frame_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl at DIV_W=2 (4-cycle slots, 32-cycle frames);
// expected outputs are queued per cycle from a frame-level reference and checked after each edge.
module tb_seg7_scan_ctrl;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [31:0] data_i = 32'd0;
   logic        load_i = 1'b0;
   logic        en_i = 1'b1;
   logic [7:0]  disp_seg_o;
   logic [7:0]  disp_an_o;
   logic        frame_o;

   typedef struct packed {
      logic [7:0] an;
      logic [7:0] seg;
      logic       frame;
   } obs_t;

   obs_t        exp_q[$];
   string       tag_q[$];
   int          n_checks = 0;
   int          n_pass = 0;
   int          t = 0;
   logic [31:0] m_disp = 32'd0;
   logic [31:0] m_shadow = 32'd0;
   logic        m_pend = 1'b0;

   seg7_scan_ctrl #(.DIV_W(2)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .data_i    (data_i),
      .load_i    (load_i),
      .en_i      (en_i),
      .disp_seg_o(disp_seg_o),
      .disp_an_o (disp_an_o),
      .frame_o   (frame_o)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] seg_of(input logic [3:0] v);
      logic [7:0] tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
      return tbl[v];
   endfunction

   task automatic check_out();
      obs_t  e;
      obs_t  o;
      string tg;
      e  = exp_q.pop_front();
      tg = tag_q.pop_front();
      o  = {disp_an_o, disp_seg_o, frame_o};
      n_checks++;
      assert (o === e) n_pass++;
      else $error("FAIL %s t=%0d: got an=%h seg=%h frame=%b, want an=%h seg=%h frame=%b",
                  tg, t, o.an, o.seg, o.frame, e.an, e.seg, e.frame);
   endtask

   // One clock with rstn high; t counts edges since reset release, frame end at t%32==0.
   task automatic step(input string tg, input logic ld, input logic [31:0] d, input logic en);
      obs_t       e;
      bit         fe;
      int         dg;
      logic [3:0] nib;
      t++;
      fe = (t % 32 == 0);
      if (fe) begin
         if (ld) m_disp = d;
         else if (m_pend) m_disp = m_shadow;
         m_pend = 1'b0;
      end else if (ld) begin
         m_pend = 1'b1;
      end
      if (ld) m_shadow = d;
      dg      = (t / 4) % 8;
      nib     = m_disp[4*dg +: 4];
      e.frame = fe;
      e.an    = 8'hFF;
      e.seg   = 8'hFF;
      if (en) begin
         e.an  = 8'(~(8'd1 << dg));
         e.seg = seg_of(nib);
`ifdef SEG7_LZ_BLANK_EN
         if (dg > 0 && (m_disp >> (4 * dg)) == 32'd0) begin
            e.an  = 8'hFF;
            e.seg = 8'hFF;
         end
`endif
      end
      exp_q.push_back(e);
      tag_q.push_back(tg);
      load_i = ld;
      data_i = d;
      en_i   = en;
      @(posedge clk);
      #1;
      check_out();
      load_i = 1'b0;
   endtask

   task automatic do_reset(input int n);
      rstn   = 1'b0;
      load_i = 1'b0;
      en_i   = 1'b1;
      for (int i = 0; i < n; i++) begin
         exp_q.push_back({8'hFF, 8'hFF, 1'b0});
         tag_q.push_back("reset");
         @(posedge clk);
         #1;
         check_out();
      end
      rstn     = 1'b1;
      t        = 0;
      m_disp   = 32'd0;
      m_shadow = 32'd0;
      m_pend   = 1'b0;
   endtask

   task automatic run_to(input string tg, input int phase);
      while (t % 32 != phase) step(tg, 1'b0, 32'd0, 1'b1);
   endtask

   task automatic run_n(input string tg, input int n, input logic en);
      for (int i = 0; i < n; i++) step(tg, 1'b0, 32'd0, en);
   endtask

   initial begin
      do_reset(3);
      run_n("scan", 64, 1'b1);

      run_to("pre_mid", 10);
      step("mid_load", 1'b1, 32'h12345678, 1'b1);
      run_n("mid_show", 60, 1'b1);

      run_to("pre_stage", 5);
      step("stage_111", 1'b1, 32'h11111111, 1'b1);
      run_to("pre_commit", 31);
      step("coinc_load", 1'b1, 32'hDEADBEEF, 1'b1);
      run_n("coinc_show", 40, 1'b1);

      run_to("pre_en", 13);
      run_n("en_off", 5, 1'b0);
      run_n("en_on", 20, 1'b1);

      run_to("pre_rst", 8);
      step("cafe_load", 1'b1, 32'hCAFEF00D, 1'b1);
      run_n("cafe_wait", 3, 1'b1);
      do_reset(2);
      run_n("post_rst", 40, 1'b1);

      step("lz_load", 1'b1, 32'h00000A30, 1'b1);
      run_n("lz_show", 70, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
